// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Sits directly after the 16-bit ALU. Each accepted op is captured with its
// destination tag. When requested, its flag nibble is committed to the
// architectural flag register. Any conditional branch is resolved against the
// flags as they stood before the op's own update. A 2-entry skid buffer lets
// writeback stall without losing or reordering results. in_ready depends only
// on the buffer state, so there is no combinational path from out_ready.
module alu_writeback_stage #(
    parameter int WIDTH = 16,
    parameter int RADDR = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_flags,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_wen,
    input  logic             in_fen,
    input  logic             in_isbr,
    input  logic [2:0]       in_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RADDR-1:0] out_rd,
    output logic             out_wen,
    output logic             br_taken,
    output logic [3:0]       flags,
    output logic [15:0]      retired
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] main_result_reg, skid_result_reg;
    logic [RADDR-1:0] main_rd_reg, skid_rd_reg;
    logic             main_wen_reg, skid_wen_reg;
    logic             main_br_reg, skid_br_reg;
    logic [3:0]       flags_reg;
    logic [15:0]      retired_reg;

    logic acc, fire, cond_true, br_new;
    logic load_main, load_skid, move_skid;

    assign in_ready  = (state_reg != TWO) & ~rst;
    assign out_valid = (state_reg != EMPTY);
    assign acc       = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    assign out_result = main_result_reg;
    assign out_rd     = main_rd_reg;
    assign out_wen    = main_wen_reg;
    assign br_taken   = main_br_reg;
    assign flags      = flags_reg;
    assign retired    = retired_reg;

    // Branch condition, evaluated against the flags committed before this op.
    // Flag order is {S,Z,C,V}.
    always_comb begin
        cond_true = 1'b0;
        case (in_cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = flags_reg[2];
            3'b010: cond_true = ~flags_reg[2];
            3'b011: cond_true = flags_reg[3] ^ flags_reg[0];
            3'b100: cond_true = ~(flags_reg[3] ^ flags_reg[0]);
            3'b101: cond_true = flags_reg[1];
            3'b110: cond_true = ~flags_reg[1];
            default: cond_true = flags_reg[0];
        endcase
    end

    assign br_new = in_isbr & cond_true;

    // The main entry is loaded from the input when the buffer is empty, or when
    // it is being replaced in the same cycle it retires. The skid entry is
    // loaded only when the main entry is stalled.
    assign load_main = acc & ((state_reg == EMPTY) | ((state_reg == ONE) & fire));
    assign load_skid = acc & (state_reg == ONE) & ~fire;
    assign move_skid = fire & (state_reg == TWO);

    // Next-state logic for the buffer occupancy FSM.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (acc) state_next = ONE;
            ONE: begin
                if (acc && !fire)      state_next = TWO;
                else if (fire && !acc) state_next = EMPTY;
            end
            TWO:   if (fire) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Occupancy state, buffer entries, flag register and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= EMPTY;
            main_result_reg <= '0;
            main_rd_reg     <= '0;
            main_wen_reg    <= 1'b0;
            main_br_reg     <= 1'b0;
            skid_result_reg <= '0;
            skid_rd_reg     <= '0;
            skid_wen_reg    <= 1'b0;
            skid_br_reg     <= 1'b0;
            flags_reg       <= 4'h0;
            retired_reg     <= 16'h0000;
        end else begin
            state_reg <= state_next;
            if (load_main) begin
                main_result_reg <= in_result;
                main_rd_reg     <= in_rd;
                main_wen_reg    <= in_wen;
                main_br_reg     <= br_new;
            end else if (move_skid) begin
                main_result_reg <= skid_result_reg;
                main_rd_reg     <= skid_rd_reg;
                main_wen_reg    <= skid_wen_reg;
                main_br_reg     <= skid_br_reg;
            end
            if (load_skid) begin
                skid_result_reg <= in_result;
                skid_rd_reg     <= in_rd;
                skid_wen_reg    <= in_wen;
                skid_br_reg     <= br_new;
            end
            // Flags commit on accept, regardless of writeback back-pressure.
            if (acc && in_fen)
                flags_reg <= in_flags;
            if (fire)
                retired_reg <= retired_reg + 16'h0001;
        end
    end

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Execute-to-writeback stage directly downstream of the 16-bit ALU. Captures the ALU result (`aout`) and flag nibble (`fout`) with their destination tag and commits the flags to the architectural flag register. It also evaluates branch conditions against that register and buffers results in a 2-entry skid buffer, so writeback back-pressure never drops or reorders an ALU result.

## Interface
Parameters:
- `WIDTH`, 16: datapath width; must match the ALU.
- `RADDR`, 3: destination register index width (8 registers).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  ALU result present this cycle.
- `in_ready`  out  1  stage can accept this cycle; a transfer occurs when `in_valid & in_ready`.
- `in_result`  in  WIDTH  ALU `aout`.
- `in_flags`  in  4  ALU `fout`, ordered {S,Z,C,V} (bit 3 = S, bit 0 = V).
- `in_rd`  in  RADDR  destination register.
- `in_wen`  in  1  register write requested.
- `in_fen`  in  1  flag register update requested.
- `in_isbr`  in  1  operation is a conditional branch.
- `in_cond`  in  3  branch condition code.
- `out_valid`  out  1  entry available for writeback.
- `out_ready`  in  1  writeback consumes; a transfer occurs when `out_valid & out_ready`.
- `out_result`  out  WIDTH  buffered result.
- `out_rd`  out  RADDR  buffered destination.
- `out_wen`  out  1  buffered write enable.
- `br_taken`  out  1  buffered branch decision; meaningful only with `out_valid`.
- `flags`  out  4  architectural flag register {S,Z,C,V}.
- `retired`  out  16  count of output transfers.

## Operation
- Buffer FSM with states EMPTY, ONE (main entry valid) and TWO (main and skid entries valid). `acc` = input transfer; `fire` = output transfer.
  - EMPTY: `acc` -> ONE (input written to main).
  - ONE: `acc & !fire` -> TWO (input written to skid). `fire & !acc` -> EMPTY. `acc & fire` -> ONE (main replaced by input).
  - TWO: `fire` -> ONE (skid moves to main). No accept is possible in TWO.
- `in_ready` = (state != TWO) & !rst. It is decoded from the state register only, with no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY). Outputs always present the main entry.
- Order is strictly FIFO. An entry is never dropped or duplicated.
- Flag register:
  - On `acc & in_fen`, `flags <= in_flags`.
  - If `in_fen=0`, flags hold.
  - The update is independent of output back-pressure.
- Branch evaluation happens at accept time, using `flags` as they were **before** this op's own update:
  - cond 000: always taken.
  - cond 001: Z.
  - cond 010: !Z.
  - cond 011: S^V (signed less-than).
  - cond 100: !(S^V).
  - cond 101: C.
  - cond 110: !C.
  - cond 111: V.
  - Stored `br_taken` = `in_isbr & cond_true`. It is 0 for non-branch ops.
- Back-to-back ops: op N+1 sees the flags written by op N, with no hazard bubble.
- `retired` increments by 1 on each `fire` and wraps from 0xFFFF to 0x0000.
- Inputs presented while `in_ready=0` are ignored. The upstream holds them.

## Timing
- Latency: an op accepted at edge N is visible on the outputs after edge N (`out_valid=1` in cycle N+1).
- Throughput is 1 op/cycle when `out_ready` is held at 1.
- `flags` change on the same edge as the accept.
- While `out_valid & !out_ready`, `out_result`, `out_rd`, `out_wen` and `br_taken` stay stable.
- When `out_valid=0`, payload outputs hold their last value.
- Reset (asynchronous, any cycle, including mid-transfer):
  - state is EMPTY.
  - `out_valid`, `out_wen`, `br_taken` are 0.
  - `out_result`, `out_rd`, `flags`, `retired` are 0.
  - `in_ready` is 0 while `rst` is high and 1 from the first cycle after release.
- Both buffer entries are discarded on reset. No transfer is counted in the reset cycle.

## Test plan
- Stream without stall: ops with results 0xFFFD, 0x000A, 0x0000, one per cycle, `out_ready=1` -> outputs appear one cycle later in order; `in_ready` stays 1; `retired` = 3.
- Stall fill and drain: `out_ready=0`, push 3 ops (rd=1,2,3) -> first two accepted, `in_ready=0` after the second, third held. Raise `out_ready` -> rd 1,2,3 emerge in order with no loss.
- Flag commit and branch: op with `in_fen=1`, `in_flags=0100` (Z), then a branch with cond 001 -> `br_taken=1`. Then an op with `in_fen=1`, flags 0000, then cond 001 -> `br_taken=0`.
- Same-op ordering: `flags=1000` (S). A branch op with cond 011, `in_fen=1`, `in_flags=0000` -> `br_taken=1` (old flags used); afterwards `flags=0000`.
- Simultaneous accept/fire in ONE: hold one entry, then assert `in_valid` and `out_ready` together -> state stays ONE, old entry retired, new entry presented next cycle.
- Reset mid-operation: buffer in TWO and `retired=0xFFFF` (forced by 0xFFFF transfers), assert `rst` asynchronously -> all outputs 0 immediately. Separately, verify `retired` wraps from 0xFFFF to 0x0000.
